// File: rtl/mem_access_pkg.sv
// Shared size codes and FSM state encoding for the load/store front end.
package mem_access_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_DONE = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend and store merge for little-endian lanes.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              uns,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b         = word[{offset, 3'b000} +: 8];
    h         = word[{offset[1], 4'b0000} +: 16];
    load_data = word;
    merged    = wdata;
    case (size)
      SIZE_B: begin
        load_data = {{(DATA_W-8){b[7] & ~uns}}, b};
        merged    = word;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        // halfword lane chosen by addr[1] only; addr[0] is ignored here
        load_data = {{(DATA_W-16){h[15] & ~uns}}, h};
        merged    = word;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the word-only data memory; sub-word stores use read-modify-write.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WORD_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [WORD_AW+1:0]   req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [WORD_AW-1:0]   mem_A,
  output logic [DATA_W-1:0]    mem_WD,
  output logic                 mem_WE,
  input  logic [DATA_W-1:0]    mem_RD
);
  state_t state, state_nx;

  logic                we_q, uns_q, err_q;
  logic [1:0]          size_q;
  logic [WORD_AW+1:0]  addr_q;
  logic [DATA_W-1:0]   wdata_q, wbuf, rdata_q;
  logic [DATA_W-1:0]   load_data, merged;
  logic                accept, misalign, word_st;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept    = req_valid && (state == IDLE);
  assign word_st   = req_we && req_size[1];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_WE    = (state == WR);
  assign mem_WD    = wbuf;
  assign mem_A     = addr_q[WORD_AW+1:2];
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .word      (mem_RD),
    .wdata     (wdata_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .uns       (uns_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = misalign ? RESP : (word_st ? WR : RD);
      RD:      state_nx = RD_DONE;
      RD_DONE: state_nx = we_q ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (word_st) wbuf <= req_wdata;
        if (misalign) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == RD_DONE) begin
        if (we_q) wbuf <= merged;
        else begin
          rdata_q <= load_data;
          err_q   <= 1'b0;
        end
      end
      // stores report zero data; updated here so the value lands with RESP
      if (state == WR) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a registered-read behavioural data memory.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err, mem_WE;
  logic [31:0] rsp_rdata, mem_WD, mem_RD;
  logic [4:0]  mem_A;

  logic [31:0] mem [32];
  int total = 0, bad = 0;
  int lat, we_cnt, a_seen;
  logic [6:0] rdy_seq, vld_seq;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_WE) mem[mem_A] <= mem_WD;
    mem_RD <= mem[mem_A];
  end

  mem_access_unit #(.DATA_W(32), .WORD_AW(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // drive one request, wait for acceptance, then measure latency to rsp_valid
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [6:0] a, input logic [31:0] wd);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; we_cnt = 0; a_seen = -1;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_WE) begin we_cnt++; a_seen = int'(mem_A); end
      if (rsp_valid) break;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int nv;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(rsp_valid), 32'd0);
    check("rst_we", 32'(mem_WE), 32'd0);
    @(negedge clk); rst = 1'b0;
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);

    // 1: word store then word load
    issue(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_we_cnt", we_cnt, 1);
    check("sw_addr", a_seen, 2);
    check("sw_rdata", rsp_rdata, 32'd0);
    check("sw_mem", mem[2], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
    check("lw_lat", lat, 3);
    check("lw_data", rsp_rdata, 32'hDEADBEEF);
    check("lw_we_cnt", we_cnt, 0);

    // 2: sub-word loads with sign/zero extension
    issue(1'b1, 2'b10, 1'b0, 7'h0C, 32'h00008F00);
    issue(1'b0, 2'b00, 1'b0, 7'h0D, 32'h0);
    check("lb_data", rsp_rdata, 32'hFFFFFF8F);
    check("lb_lat", lat, 3);
    issue(1'b0, 2'b00, 1'b1, 7'h0D, 32'h0);
    check("lbu_data", rsp_rdata, 32'h0000008F);
    issue(1'b0, 2'b01, 1'b0, 7'h0C, 32'h0);
    check("lh_data", rsp_rdata, 32'hFFFF8F00);

    // 3: read-modify-write sub-word stores
    issue(1'b1, 2'b10, 1'b0, 7'h10, 32'h11223344);
    issue(1'b1, 2'b01, 1'b0, 7'h12, 32'h0000ABCD);
    check("sh_lat", lat, 4);
    check("sh_we_cnt", we_cnt, 1);
    check("sh_addr", a_seen, 4);
    check("sh_mem", mem[4], 32'hABCD3344);
    issue(1'b1, 2'b00, 1'b0, 7'h10, 32'h00000055);
    check("sb_lat", lat, 4);
    check("sb_mem", mem[4], 32'hABCD3355);
    issue(1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
    check("sb_readback", rsp_rdata, 32'hABCD3355);

    // 4: misaligned word load
    issue(1'b1, 2'b10, 1'b0, 7'h04, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 7'h05, 32'h0);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_lat", lat, 1);
    check("mis_err", 32'(rsp_err), 32'd1);
    check("mis_rdata", rsp_rdata, 32'd0);
    check("mis_we_cnt", we_cnt, 0);
`else
    check("mis_lat", lat, 3);
    check("mis_err", 32'(rsp_err), 32'd0);
    check("mis_rdata", rsp_rdata, 32'hCAFEF00D);
`endif

    // 5: req_valid held across two back-to-back loads
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 7'h08;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    rdy_seq = '0; vld_seq = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      rdy_seq[c-1] = req_ready;
      vld_seq[c-1] = rsp_valid;
      if (c == 5) req_valid = 1'b0;
    end
    check("b2b_ready_seq", 32'(rdy_seq), 32'b0001000);
    check("b2b_valid_seq", 32'(vld_seq), 32'b1000100);
    check("b2b_data", rsp_rdata, 32'hDEADBEEF);

    // 6: reset during RD of a sub-word store
    issue(1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
    check("pre_rst_data", rsp_rdata, 32'hABCD3355);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 7'h10;
    req_wdata = 32'h00000077;
    @(posedge clk); #1 req_valid = 1'b0;
    check("abort_in_rd_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_we", 32'(mem_WE), 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    nv = 0;
    repeat (3) begin @(negedge clk); nv += int'(rsp_valid) + int'(mem_WE); end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); nv += int'(rsp_valid) + int'(mem_WE); end
    check("abort_no_activity", nv, 0);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    check("abort_mem", mem[4], 32'hABCD3355);
    issue(1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
    check("abort_readback", rsp_rdata, 32'hABCD3355);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
